// File: rtl/sequenciador_varredura_pkg.sv
// Shared definitions for the scan sequencer: state encoding, direction
// codes, select width and the select advance helpers.
package sequenciador_varredura_pkg;

    localparam int LARGURA_SEL = 3;

    typedef enum logic {
        PARADO   = 1'b0,
        VARRENDO = 1'b1
    } estado_t;

    localparam logic SENTIDO_CRESC = 1'b0;
    localparam logic SENTIDO_DECR  = 1'b1;

    // Next select value in the requested direction, wrapping inside 0..ultimo.
    function automatic logic [LARGURA_SEL-1:0] proximo_sel(
        input logic [LARGURA_SEL-1:0] sel,
        input logic                   sentido,
        input logic [LARGURA_SEL-1:0] ultimo
    );
        logic [LARGURA_SEL-1:0] resultado;
        if (sentido == SENTIDO_DECR) begin
            resultado = (sel == '0) ? ultimo : sel - LARGURA_SEL'(1);
        end else begin
            resultado = (sel == ultimo) ? '0 : sel + LARGURA_SEL'(1);
        end
        return resultado;
    endfunction

    // True when the advance from sel in this direction wraps around.
    function automatic logic vai_virar(
        input logic [LARGURA_SEL-1:0] sel,
        input logic                   sentido,
        input logic [LARGURA_SEL-1:0] ultimo
    );
        logic resultado;
        if (sentido == SENTIDO_DECR) begin
            resultado = (sel == '0);
        end else begin
            resultado = (sel == ultimo);
        end
        return resultado;
    endfunction

endpackage

// File: rtl/sequenciador_varredura_divisor_tick.sv
// Programmable prescaler: counts 0..DIVISOR-1 while enabled and flags the
// last count so the owner can advance on that edge. clear wins over enable.
module divisor_tick
    import sequenciador_varredura_pkg::*;
#(
    parameter int DIVISOR = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic pulse
);

    localparam int LARGURA = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [LARGURA-1:0] MAXIMO = LARGURA'(DIVISOR - 1);

    logic [LARGURA-1:0] count_q;
    logic [LARGURA-1:0] count_d;

    assign pulse = (count_q == MAXIMO);

    // Next count: clear to zero, otherwise count up and wrap at the last value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == MAXIMO) begin
                count_d = '0;
            end else begin
                count_d = count_q + LARGURA'(1);
            end
        end
    end

    // Count register, zeroed by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sequenciador_varredura.sv
// Run/stop scanner producing the select code for the downstream 3-to-8
// decoder. Handles load, stop, start, single step and timed advance, with
// registered tick/fim_ciclo pulses marking each advance and each wrap.
module sequenciador_varredura
    import sequenciador_varredura_pkg::*;
#(
    parameter int DIVISOR = 4,
    parameter int ULTIMO  = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic                   parar,
    input  logic                   passo,
    input  logic                   sentido,
    input  logic                   carregar,
    input  logic [LARGURA_SEL-1:0] valor,
    output logic [LARGURA_SEL-1:0] sel,
    output logic                   ativo,
    output logic                   tick,
    output logic                   fim_ciclo
);

    localparam logic [LARGURA_SEL-1:0] ULTIMO_SEL = LARGURA_SEL'(ULTIMO);

    estado_t                estado_q;
    estado_t                estado_d;
    logic [LARGURA_SEL-1:0] sel_q;
    logic [LARGURA_SEL-1:0] sel_d;
    logic                   tick_q;
    logic                   tick_d;
    logic                   fim_ciclo_q;
    logic                   fim_ciclo_d;
    logic                   pre_clear;
    logic                   pre_enable;
    logic                   pre_pulse;
    logic                   avancar;

    divisor_tick #(
        .DIVISOR(DIVISOR)
    ) u_divisor_tick (
        .clk   (clk),
        .reset (reset),
        .clear (pre_clear),
        .enable(pre_enable),
        .pulse (pre_pulse)
    );

    // Per-edge decision in priority order: load, stop, start, step, timed advance.
    always_comb begin
        estado_d    = estado_q;
        sel_d       = sel_q;
        tick_d      = 1'b0;
        fim_ciclo_d = 1'b0;
        pre_clear   = 1'b0;
        pre_enable  = (estado_q == VARRENDO);
        avancar     = 1'b0;

        if (carregar) begin
            sel_d     = (valor > ULTIMO_SEL) ? ULTIMO_SEL : valor;
            pre_clear = 1'b1;
        end else if (parar) begin
            if (estado_q == VARRENDO) begin
                estado_d  = PARADO;
                pre_clear = 1'b1;
            end
        end else if (iniciar && (estado_q == PARADO)) begin
            estado_d  = VARRENDO;
            pre_clear = 1'b1;
        end else if (passo && (estado_q == PARADO)) begin
            avancar = 1'b1;
        end else if ((estado_q == VARRENDO) && pre_pulse) begin
            avancar = 1'b1;
        end

        if (avancar) begin
            sel_d       = proximo_sel(sel_q, sentido, ULTIMO_SEL);
            tick_d      = 1'b1;
            fim_ciclo_d = vai_virar(sel_q, sentido, ULTIMO_SEL);
        end
    end

    // State, select and pulse registers; reset aborts any pending pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q    <= PARADO;
            sel_q       <= '0;
            tick_q      <= 1'b0;
            fim_ciclo_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            sel_q       <= sel_d;
            tick_q      <= tick_d;
            fim_ciclo_q <= fim_ciclo_d;
        end
    end

    assign sel       = sel_q;
    assign ativo     = (estado_q == VARRENDO);
    assign tick      = tick_q;
    assign fim_ciclo = fim_ciclo_q;

endmodule

// File: tb/tb_sequenciador_varredura.sv
// Scoreboard bench for the scan sequencer. Two instances with different
// DIVISOR/ULTIMO share the same stimulus; a cycle-level reference model
// predicts each instance and a negedge monitor compares against the queue.
module tb_sequenciador_varredura;

    localparam int DIV_A = 4;
    localparam int ULT_A = 7;
    localparam int DIV_B = 1;
    localparam int ULT_B = 5;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       iniciar  = 1'b0;
    logic       parar    = 1'b0;
    logic       passo    = 1'b0;
    logic       sentido  = 1'b0;
    logic       carregar = 1'b0;
    logic [2:0] valor    = 3'd0;

    logic [1:0][2:0] dut_sel;
    logic [1:0]      dut_ativo;
    logic [1:0]      dut_tick;
    logic [1:0]      dut_fim;

    typedef struct {
        int              tag;
        logic [1:0][2:0] sel;
        logic [1:0]      ativo;
        logic [1:0]      tick;
        logic [1:0]      fim;
    } esperado_t;

    esperado_t fila[$];

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    int div_p[2] = '{DIV_A, DIV_B};
    int ult_p[2] = '{ULT_A, ULT_B};
    int m_run[2];
    int m_sel[2];
    int m_left[2];
    int m_tick[2];
    int m_fim[2];

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    sequenciador_varredura #(.DIVISOR(DIV_A), .ULTIMO(ULT_A)) dut_a (
        .clk(clk), .reset(reset), .iniciar(iniciar), .parar(parar),
        .passo(passo), .sentido(sentido), .carregar(carregar), .valor(valor),
        .sel(dut_sel[0]), .ativo(dut_ativo[0]), .tick(dut_tick[0]),
        .fim_ciclo(dut_fim[0])
    );

    sequenciador_varredura #(.DIVISOR(DIV_B), .ULTIMO(ULT_B)) dut_b (
        .clk(clk), .reset(reset), .iniciar(iniciar), .parar(parar),
        .passo(passo), .sentido(sentido), .carregar(carregar), .valor(valor),
        .sel(dut_sel[1]), .ativo(dut_ativo[1]), .tick(dut_tick[1]),
        .fim_ciclo(dut_fim[1])
    );

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string nome, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", nome, actual, expected, $time);
        end
    endtask

    // Reference model: the scanner described as "cycles left until the next move".
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i]  = 0;
            m_sel[i]  = 0;
            m_left[i] = div_p[i];
            m_tick[i] = 0;
            m_fim[i]  = 0;
        end
    endtask

    task automatic model_advance(input int i);
        if (sentido == 1'b0) begin
            m_fim[i] = (m_sel[i] == ult_p[i]) ? 1 : 0;
            m_sel[i] = (m_fim[i] != 0) ? 0 : m_sel[i] + 1;
        end else begin
            m_fim[i] = (m_sel[i] == 0) ? 1 : 0;
            m_sel[i] = (m_fim[i] != 0) ? ult_p[i] : m_sel[i] - 1;
        end
        m_tick[i] = 1;
    endtask

    task automatic model_step(input int i);
        m_tick[i] = 0;
        m_fim[i]  = 0;
        if (reset) begin
            m_run[i]  = 0;
            m_sel[i]  = 0;
            m_left[i] = div_p[i];
        end else if (carregar) begin
            m_sel[i]  = (int'(valor) > ult_p[i]) ? ult_p[i] : int'(valor);
            m_left[i] = div_p[i];
        end else if (parar) begin
            if (m_run[i] != 0) begin
                m_run[i]  = 0;
                m_left[i] = div_p[i];
            end
        end else if (iniciar && m_run[i] == 0) begin
            m_run[i]  = 1;
            m_left[i] = div_p[i];
        end else if (passo && m_run[i] == 0) begin
            model_advance(i);
        end else if (m_run[i] != 0) begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
                model_advance(i);
                m_left[i] = div_p[i];
            end
        end
    endtask

    // Drive one cycle of inputs away from the edge and queue the predicted result.
    task automatic applyStimulus(input logic rst, input logic ini, input logic par,
                                 input logic pas, input logic sen, input logic car,
                                 input logic [2:0] val);
        esperado_t e;
        @(posedge clk);
        #2;
        reset    = rst;
        iniciar  = ini;
        parar    = par;
        passo    = pas;
        sentido  = sen;
        carregar = car;
        valor    = val;
        e.tag = edge_cnt + 1;
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            e.sel[i]   = 3'(m_sel[i]);
            e.ativo[i] = (m_run[i] != 0);
            e.tick[i]  = (m_tick[i] != 0);
            e.fim[i]   = (m_fim[i] != 0);
        end
        fila.push_back(e);
    endtask

    task automatic idle(input int n, input logic sen);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, sen, 1'b0, 3'd0);
    endtask

    // Monitor: on each falling edge, retire the prediction made for the last rising edge.
    initial begin
        esperado_t e;
        forever begin
            @(negedge clk);
            if (fila.size() > 0 && fila[0].tag == edge_cnt) begin
                e = fila.pop_front();
                for (int i = 0; i < 2; i++) begin
                    checkOutput($sformatf("sel_%0d", i),   int'(dut_sel[i]),   int'(e.sel[i]));
                    checkOutput($sformatf("ativo_%0d", i), int'(dut_ativo[i]), int'(e.ativo[i]));
                    checkOutput($sformatf("tick_%0d", i),  int'(dut_tick[i]),  int'(e.tick[i]));
                    checkOutput($sformatf("fim_%0d", i),   int'(dut_fim[i]),   int'(e.fim[i]));
                end
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        int   espera;
        logic sen;
        model_reset();
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        // Continuous up-scan through a full wrap.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(36, 1'b0);

        // Down-scan from zero.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        idle(16, 1'b1);

        // Single steps while stopped, then start with passo held.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
            idle(2, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        idle(3, 1'b0);

        // Load mid-count while scanning, with an out-of-range value.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
        idle(6, 1'b0);

        // Start and stop together while stopped; stop exactly on an advance edge.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(2, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(3, 1'b0);

        // Asynchronous reset in the middle of a scan at sel=4.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        espera = 0;
        while (m_sel[0] != 4 && espera < 100) begin
            idle(1, 1'b0);
            espera++;
        end
        checkOutput("reach_sel4_budget", (m_sel[0] == 4) ? 1 : 0, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        fila.delete();
        #1;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("async_rst_sel_%0d", i),   int'(dut_sel[i]),   0);
            checkOutput($sformatf("async_rst_ativo_%0d", i), int'(dut_ativo[i]), 0);
            checkOutput($sformatf("async_rst_tick_%0d", i),  int'(dut_tick[i]),  0);
            checkOutput($sformatf("async_rst_fim_%0d", i),   int'(dut_fim[i]),   0);
        end
        model_reset();
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        idle(1, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("onehot_a", int'(8'd1 << dut_sel[0]), 1);
        checkOutput("onehot_b", int'(8'd1 << dut_sel[1]), 1);

        // Randomized mix of all controls.
        sen = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) sen = ~sen;
            applyStimulus(1'b0,
                          $urandom_range(0, 99) < 10,
                          $urandom_range(0, 99) < 6,
                          $urandom_range(0, 99) < 25,
                          sen,
                          $urandom_range(0, 99) < 4,
                          3'($urandom_range(0, 7)));
        end
        idle(2, 1'b0);

        espera = 0;
        while (fila.size() > 0 && espera < 10) begin
            @(negedge clk);
            #1;
            espera++;
        end
        checkOutput("scoreboard_drained", fila.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequenciador_varredura.md
Name: sequenciador_varredura

Overview:
Generates the 3-bit select code that drives the downstream 3-to-8 one-hot decoder, so that the decoder outputs s0..s7 are scanned in sequence. The block is a run/stop scanner with a programmable step period, up/down direction, single-step and load. It sits directly upstream of the decoder and owns all timing of the scan; the decoder itself stays purely combinational.

Parameters:
DIVISOR, 4, clock cycles per scan step while running (legal range 1..256).
ULTIMO, 7, highest select index used; the scan covers 0..ULTIMO (legal range 1..7).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
iniciar  in  1  start continuous scan (level sampled each cycle)
parar  in  1  stop scan
passo  in  1  single-step request; honoured only while stopped
sentido  in  1  0 = count up, 1 = count down
carregar  in  1  load sel from valor
valor  in  3  load value
sel  out  3  select code to the decoder
ativo  out  1  1 while in state VARRENDO
tick  out  1  one-cycle pulse in the first cycle sel shows a new value from an advance
fim_ciclo  out  1  one-cycle pulse, coincident with tick, when the advance wrapped

Behaviour:
- One clock and one asynchronous, active-high reset; all outputs are registered.
- Reset (async assert, released on clk): state PARADO, sel=0, prescaler=0, ativo=0, tick=0, fim_ciclo=0.
- FSM states: PARADO and VARRENDO. ativo=1 exactly when the state is VARRENDO.
- Per-edge priority is carregar > parar > iniciar > passo > prescaler advance.
- carregar: sel <= valor, saturated to ULTIMO when valor > ULTIMO.
  - Prescaler cleared; state unchanged; no tick or fim_ciclo.
- parar (no carregar):
  - From VARRENDO: go to PARADO, prescaler cleared, sel held.
  - From PARADO: no effect.
- iniciar (no carregar or parar):
  - From PARADO: go to VARRENDO, prescaler cleared.
  - The first advance occurs DIVISOR cycles after the iniciar edge.
  - From VARRENDO: no effect. iniciar and parar asserted together gives parar.
- VARRENDO advance:
  - The prescaler counts 0..DIVISOR-1.
  - On the edge where prescaler == DIVISOR-1, prescaler <= 0 and sel advances.
  - With DIVISOR=1, sel advances every cycle.
- passo in PARADO: sel advances on that edge. Held high, it advances every cycle (no edge detection). Ignored in VARRENDO.
- Advance rule:
  - Up: sel == ULTIMO -> 0 (wrap), else sel+1.
  - Down: sel == 0 -> ULTIMO (wrap), else sel-1.
  - sentido is sampled at the advance edge, so a direction change takes effect on the next advance.
- tick=1 for exactly the cycle after an advance edge; fim_ciclo=1 in that same cycle only if the advance wrapped. Both are 0 otherwise, including after a load.
- Out-of-range sel (> ULTIMO) is unreachable: reset gives 0, loads saturate, advances stay in range.
- Prescaler width is clog2(DIVISOR), minimum 1 bit. No arithmetic overflow is possible.
- Reset asserted mid-scan aborts immediately to the reset values; no pending tick survives.

Decomposition:
- Shared package holds:
  - State encoding constants PARADO=1'b0, VARRENDO=1'b1.
  - Direction constants SENTIDO_CRESC=0, SENTIDO_DECR=1.
  - Select width constant LARGURA_SEL=3.
- One sub-module is natural: divisor_tick, a parameterised prescaler with inputs clk, reset, clear, enable and output pulse (high when count == DIVISOR-1).
- The FSM, the sel register and the advance logic stay in the top module.
- The integration bench instantiates sequenciador_varredura feeding decodificador_3bits and checks one-hot outputs.

Test Plan:
1. Reset, then iniciar for 1 cycle with DIVISOR=4, ULTIMO=7, sentido=0 -> sel goes 0,1,2,...,7,0 with each value held 4 cycles. tick pulses every 4 cycles. fim_ciclo pulses only with the 7->0 advance. ativo=1 throughout.
2. ULTIMO=5, DIVISOR=1, sentido=1 from sel=0 -> sel goes 5,4,3,2,1,0,5 on consecutive cycles. fim_ciclo is high with each 0->5 wrap.
3. While stopped at sel=3, pulse passo 3 times (1 cycle each, gaps between) -> sel goes 4,5,6 with one tick per step and ativo=0. Hold passo with iniciar=1 in the same cycle -> state goes to VARRENDO and sel does not step.
4. carregar=1 with valor=6, ULTIMO=5, in VARRENDO at prescaler=2 -> next cycle sel=5, tick=0, prescaler=0, still VARRENDO. The next advance comes 4 cycles later (up: sel=0, fim_ciclo=1).
5. iniciar=1 and parar=1 asserted together while in PARADO -> stays PARADO. In VARRENDO, parar on the edge where prescaler==3 -> sel does not advance, and the state is PARADO.
6. Assert reset asynchronously mid-scan at sel=4 -> sel=0, ativo=0, tick=0, fim_ciclo=0 immediately, with no clock edge. After release, the decoder one-hot output is s0 only.
